conv_accumulator: RTL and testbench
===================================

# conv_accumulator

Final-stage accumulator of a K×K convolution engine. Each valid cycle it takes K signed partial sums from the K PE rows, each already reduced over one kernel row and all input channels. It adds them into one full-precision convolution result and returns that result with a valid flag. The block sits between the PE array and the output/activation stage and runs one result per cycle at full throughput.

## Interface
- IFM_BIT, 8: input feature-map bit width.
- W_BIT, 8: weight bit width.
- K, 3: kernel size; number of PE lanes.
- IN_CH, 512: input channel count.
- BIT_PE (localparam) = IFM_BIT + W_BIT + $clog2(K*IN_CH): lane width, 27 at defaults.
- BIT_ACCUMULATOR (localparam) = IFM_BIT + W_BIT + $clog2(K*K*IN_CH): result width, 29 at defaults.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: synchronous, active-high reset. The name is kept for codebase compatibility. Reset acts when it is 1 at a rising edge.
- in_valid, input, 1: PE holds a valid set of K lanes this cycle.
- PE, input, K*BIT_PE: packed lanes. Lane i = PE[i*BIT_PE +: BIT_PE], signed two's complement.
- out_valid, output, 1: Accumulator holds a valid result.
- Accumulator, output, BIT_ACCUMULATOR: signed two's-complement sum of the K lanes.

## Operation
- Each lane is sign-extended to BIT_ACCUMULATOR, then all K lanes are summed.
- Summation uses a generic adder tree, parameterised on K, with no truncation. BIT_ACCUMULATOR ≥ BIT_PE + $clog2(K), so overflow is impossible and no saturation is needed.
- Each in_valid=1 cycle produces exactly one result. in_valid=0 cycles produce nothing.
- There is no back-pressure. The block accepts a new input every cycle.
- There is no FSM. The block is a fixed-depth pipeline with a valid bit carried alongside the data.
- Accumulator is forced to 0 whenever out_valid=0. It never holds stale data.
- All state is internal. Inputs are sampled only on rising edges where in_valid=1; PE is don't-care otherwise.

## Timing
- Reset values: out_valid=0, Accumulator=0, all internal pipeline valid bits and data registers cleared.
- Default latency is 1 cycle. Inputs sampled at edge N appear on Accumulator/out_valid after edge N (registered outputs). Outputs are never combinational from inputs.
- Back-to-back in_valid yields back-to-back out_valid with results in input order.
- Gaps in in_valid give matching gaps in out_valid, with Accumulator=0 during the gaps.
- Reset mid-stream discards all in-flight results. out_valid is 0 in the cycle after reset.
- If reset and in_valid are both 1 on the same edge, reset wins and the input is dropped.
- The first in_valid accepted after reset deasserts produces its result with normal latency.

## Configuration
- ACC_INPUT_REG_EN defined: adds an input register stage (PE and in_valid captured first, adder tree in the second stage). Latency becomes 2 cycles, throughput stays 1/cycle, and all reset and flush rules above still apply.
- ACC_INPUT_REG_EN undefined: latency is 1 cycle as specified above.
- Arithmetic results are identical in both builds. Only latency differs.

## Test plan
- Reset: hold rst_n=1 for 3 cycles with in_valid=1 and random PE -> out_valid=0 and Accumulator=0 throughout and one cycle after release.
- Simple sum: lanes {1,2,3}, one valid cycle -> one out_valid pulse with Accumulator=6 after the configured latency (1, or 2 with ACC_INPUT_REG_EN), then 0.
- Signed mix: lanes {100,-50,-25} -> 25. Lanes {-1,-1,-1} -> -3, i.e. 0x1FFFFFFD.
- Extremes: all lanes 2^26-1 -> 201326589. All lanes -2^26 -> -201326592, i.e. 0x14000000. No wrap in either case.
- Streaming: 100 consecutive random valid cycles, then alternating valid/idle -> out_valid mirrors in_valid delayed by the configured latency, every sum matches the reference model, and Accumulator=0 on idle cycles.
- Reset mid-stream: assert rst_n for 1 cycle during continuous input -> the in-flight result is dropped and the stream resumes correctly from the first post-reset input.

Source files
------------

// File: rtl/conv_accumulator.sv
// rtl/conv_accumulator.sv - K-lane signed adder tree with registered valid/result (ACC_INPUT_REG_EN adds an input stage)
module conv_accumulator #(
  parameter int IFM_BIT = 8,
  parameter int W_BIT   = 8,
  parameter int K       = 3,
  parameter int IN_CH   = 512,
  localparam int BIT_PE          = IFM_BIT + W_BIT + $clog2(K * IN_CH),
  localparam int BIT_ACCUMULATOR = IFM_BIT + W_BIT + $clog2(K * K * IN_CH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [K*BIT_PE-1:0]               PE,
  output logic                              out_valid,
  output logic [BIT_ACCUMULATOR-1:0]        Accumulator
);

  localparam int LEVELS = $clog2(K);
  localparam int NLEAF  = 1 << LEVELS;

  logic [K*BIT_PE-1:0]                 pe_src;
  logic                                stage_valid;
  logic signed [BIT_ACCUMULATOR-1:0]   tree_sum;
  logic                                out_valid_q, out_valid_d;
  logic [BIT_ACCUMULATOR-1:0]          acc_q, acc_d;

`ifdef ACC_INPUT_REG_EN
  logic [K*BIT_PE-1:0] pe_q, pe_d;
  logic                pe_valid_q, pe_valid_d;

  // PE is only captured on valid cycles so idle-cycle garbage never enters the tree.
  always_comb begin
    pe_d       = in_valid ? PE : pe_q;
    pe_valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pe_q       <= '0;
      pe_valid_q <= 1'b0;
    end else begin
      pe_q       <= pe_d;
      pe_valid_q <= pe_valid_d;
    end
  end

  assign pe_src      = pe_q;
  assign stage_valid = pe_valid_q;
`else
  assign pe_src      = PE;
  assign stage_valid = in_valid;
`endif

  // Binary tree padded to a power of two; missing leaves are zero.
  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    localparam int N = NLEAF >> l;
    logic signed [BIT_ACCUMULATOR-1:0] sum [N];
    if (l == 0) begin : leaf
      for (genvar i = 0; i < NLEAF; i++) begin : ln
        if (i < K) begin : used
          assign sum[i] = BIT_ACCUMULATOR'($signed(pe_src[i*BIT_PE +: BIT_PE]));
        end else begin : pad
          assign sum[i] = '0;
        end
      end
    end else begin : add
      for (genvar i = 0; i < N; i++) begin : an
        assign sum[i] = lvl[l-1].sum[2*i] + lvl[l-1].sum[2*i+1];
      end
    end
  end

  assign tree_sum = lvl[LEVELS].sum[0];

  always_comb begin
    out_valid_d = stage_valid;
    acc_d       = stage_valid ? tree_sum : '0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_valid_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign Accumulator = acc_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// tb/tb_conv_accumulator.sv - scoreboard bench for conv_accumulator (honours ACC_INPUT_REG_EN)
module tb_conv_accumulator;

  localparam int K     = 3;
  localparam int BP    = 27;
  localparam int BA    = 29;
`ifdef ACC_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [K*BP-1:0]   PE;
  logic              out_valid;
  logic [BA-1:0]     Accumulator;

  int n_checks = 0;
  int n_errors = 0;

  longint      lanes [K];
  logic [63:0] sb [$];
  bit          vpipe [LAT];

  conv_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .PE          (PE),
    .out_valid   (out_valid),
    .Accumulator (Accumulator)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive, let the edge happen, update the model, then compare.
  task automatic step(input bit rst, input bit v);
    longint      sum;
    logic [63:0] e;
    rst_n    = rst;
    in_valid = v;
    for (int i = 0; i < K; i++) PE[i*BP +: BP] = lanes[i][BP-1:0];
    @(posedge clk);
    if (rst) begin
      sb.delete();
      for (int i = 0; i < LAT; i++) vpipe[i] = 1'b0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) vpipe[i] = vpipe[i-1];
      vpipe[0] = v;
      if (v) begin
        sum = 0;
        for (int i = 0; i < K; i++) sum += lanes[i];
        e = '0;
        e[BA-1:0] = sum[BA-1:0];
        sb.push_back(e);
      end
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(vpipe[LAT-1]));
    if (out_valid) begin
      if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
      else check("acc", 64'(Accumulator), sb.pop_front());
    end else begin
      check("acc_idle", 64'(Accumulator), 64'd0);
    end
  endtask

  task automatic rand_lanes();
    logic signed [BP-1:0] r;
    for (int i = 0; i < K; i++) begin
      r = BP'($urandom);
      lanes[i] = longint'(r);
    end
  endtask

  task automatic set3(input longint a, input longint b, input longint c);
    lanes[0] = a; lanes[1] = b; lanes[2] = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_lanes();
      step(1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; PE = '0;
    for (int i = 0; i < LAT; i++) vpipe[i] = 1'b0;

    // Reset held with valid traffic present
    for (int i = 0; i < 3; i++) begin
      rand_lanes();
      step(1'b1, 1'b1);
    end
    idle(1);

    // Directed sums
    set3(1, 2, 3);                       step(1'b0, 1'b1); idle(LAT + 1);
    set3(100, -50, -25);                 step(1'b0, 1'b1); idle(LAT);
    set3(-1, -1, -1);                    step(1'b0, 1'b1); idle(LAT);
    set3(67108863, 67108863, 67108863);  step(1'b0, 1'b1); idle(LAT);
    set3(-67108864, -67108864, -67108864); step(1'b0, 1'b1); idle(LAT);
    set3(67108863, -67108864, 67108863); step(1'b0, 1'b1);
    set3(-67108864, -67108864, -67108864); step(1'b0, 1'b1); idle(LAT);

    // Streaming: back-to-back, then alternating
    for (int i = 0; i < 100; i++) begin
      rand_lanes();
      step(1'b0, 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      rand_lanes();
      step(1'b0, (i % 2) == 0);
    end
    idle(LAT);

    // Reset pulse during continuous input
    for (int i = 0; i < 10; i++) begin
      rand_lanes();
      step(1'b0, 1'b1);
    end
    rand_lanes();
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      rand_lanes();
      step(1'b0, 1'b1);
    end
    idle(LAT + 2);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
